// File: rtl/vga_encouracado_pkg.sv
// vga_encouracado_pkg
//   Shared definitions for the battleship colour layer:
//   - 9-bit {r,g,b} colour constants (3 bits per channel)
//   - board geometry constant BOARD_CELLS
//   - ship descriptor layout (field offsets and a packed struct view)
//   - pixel classification enum and its colour lookup
package vga_encouracado_pkg;

    localparam int unsigned BOARD_CELLS = 10;

    // Colours, packed as {r[2:0], g[2:0], b[2:0]}
    localparam logic [8:0] BLACK      = {3'd0, 3'd0, 3'd0};
    localparam logic [8:0] BACKGROUND = {3'd1, 3'd1, 3'd1};
    localparam logic [8:0] GRID       = {3'd3, 3'd3, 3'd3};
    localparam logic [8:0] HIT        = {3'd7, 3'd0, 3'd0};
    localparam logic [8:0] SHIP       = {3'd5, 3'd5, 3'd5};
    localparam logic [8:0] WATER      = {3'd0, 3'd2, 3'd6};

    // Ship descriptor field offsets
    localparam int unsigned DESC_W          = 13;
    localparam int unsigned DESC_COL_LSB    = 0;
    localparam int unsigned DESC_ROW_LSB    = 4;
    localparam int unsigned DESC_ORIENT_BIT = 8;
    localparam int unsigned DESC_HIT_LSB    = 9;
    localparam int unsigned HIT_BITS        = 4;

    // Struct view of the descriptor; field order matches the offsets above
    typedef struct packed {
        logic [3:0] hits;      // [12:9] bit k set = segment k hit, k=0 at bow
        logic       vertical;  // [8]    0 = grows with column, 1 = grows with row
        logic [3:0] row;       // [7:4]  bow row
        logic [3:0] col;       // [3:0]  bow column
    } ship_desc_t;

    typedef enum logic [2:0] {
        PIX_BLANK,
        PIX_BACKGROUND,
        PIX_GRID,
        PIX_HIT,
        PIX_SHIP,
        PIX_WATER
    } pix_class_t;

    function automatic logic [8:0] class_colour(input pix_class_t pix);
        logic [8:0] colour;
        colour = BLACK;
        case (pix)
            PIX_BLANK:      colour = BLACK;
            PIX_BACKGROUND: colour = BACKGROUND;
            PIX_GRID:       colour = GRID;
            PIX_HIT:        colour = HIT;
            PIX_SHIP:       colour = SHIP;
            PIX_WATER:      colour = WATER;
            default:        colour = BLACK;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vga_cell_locator.sv
// vga_cell_locator
//   Combinational mapping of a pixel coordinate onto the 10x10 board.
//   Ports:
//     linha    in  10  pixel line
//     coluna   in  10  pixel column
//     on_board out 1   pixel lies inside the board square
//     row      out 4   board row of the pixel (valid when on_board)
//     col      out 4   board column of the pixel (valid when on_board)
//     grid     out 1   pixel is on a grid line (cell edge or last board line/column)
module vga_cell_locator #(
    parameter int unsigned BOARD_X0 = 160,
    parameter int unsigned BOARD_Y0 = 80,
    parameter int unsigned CELL_PX  = 32
) (
    input  logic [9:0] linha,
    input  logic [9:0] coluna,
    output logic       on_board,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       grid
);
    import vga_encouracado_pkg::*;

    localparam int unsigned BOARD_PX   = BOARD_CELLS * CELL_PX;
    localparam int unsigned CELL_SHIFT = $clog2(CELL_PX);

    localparam logic [9:0] X_FIRST     = 10'(BOARD_X0);
    localparam logic [9:0] X_LAST      = 10'(BOARD_X0 + BOARD_PX - 1);
    localparam logic [9:0] Y_FIRST     = 10'(BOARD_Y0);
    localparam logic [9:0] Y_LAST      = 10'(BOARD_Y0 + BOARD_PX - 1);
    localparam logic [9:0] OFFSET_MASK = 10'(CELL_PX - 1);

    if ((CELL_PX == 0) || ((CELL_PX & (CELL_PX - 1)) != 0)) begin : g_bad_cell
        $error("vga_cell_locator: CELL_PX must be a power of two");
    end
    if ((BOARD_X0 + BOARD_PX > 1024) || (BOARD_Y0 + BOARD_PX > 1024)) begin : g_bad_origin
        $error("vga_cell_locator: board does not fit 10-bit coordinates");
    end

    logic       in_x;
    logic       in_y;
    logic [9:0] dx;
    logic [9:0] dy;

    always_comb begin
        // Range is established before subtracting so dx/dy never wrap
        in_x = (coluna >= X_FIRST) && (coluna <= X_LAST);
        in_y = (linha  >= Y_FIRST) && (linha  <= Y_LAST);
        dx   = in_x ? (coluna - X_FIRST) : '0;
        dy   = in_y ? (linha  - Y_FIRST) : '0;

        on_board = in_x && in_y;
        col      = 4'(dx >> CELL_SHIFT);
        row      = 4'(dy >> CELL_SHIFT);

        grid = on_board && (((dx & OFFSET_MASK) == '0) ||
                            ((dy & OFFSET_MASK) == '0) ||
                            (coluna == X_LAST)         ||
                            (linha  == Y_LAST));
    end

endmodule

// File: rtl/vga_encouracado.sv
// vga_encouracado
//   Battleship layer colour generator. Classifies each pixel as blank,
//   background, grid, ship hit, ship intact or water and registers the
//   resulting 3-bit R/G/B with one cycle of latency.
//   Optional feature: define VGA_ENCOURACADO_GRID_EN to draw grid lines;
//   without it grid pixels fall through to ship/water colouring.
//   Ports:
//     clk                in  1   pixel clock
//     rst                in  1   asynchronous active-high reset, forces rgb to 0
//     areaAtiva          in  1   visible pixel
//     linha              in  10  pixel line
//     coluna             in  10  pixel column
//     posicoesEmbarcacao in  13  ship descriptor {hits[3:0], vertical, row[3:0], col[3:0]}
//     rgb_r/rgb_g/rgb_b  out 3   registered colour
module vga_encouracado #(
    parameter int unsigned BOARD_X0 = 160,
    parameter int unsigned BOARD_Y0 = 80,
    parameter int unsigned CELL_PX  = 32,
    parameter int unsigned SHIP_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        areaAtiva,
    input  logic [9:0]  linha,
    input  logic [9:0]  coluna,
    input  logic [12:0] posicoesEmbarcacao,
    output logic [2:0]  rgb_r,
    output logic [2:0]  rgb_g,
    output logic [2:0]  rgb_b
);
    import vga_encouracado_pkg::*;

    localparam logic [4:0] SHIP_LEN_W = 5'(SHIP_LEN);
    localparam logic [3:0] LAST_CELL  = 4'(BOARD_CELLS - 1);
    localparam logic [3:0] HIT_LIMIT  = 4'(HIT_BITS);

    if ((SHIP_LEN == 0) || (SHIP_LEN > BOARD_CELLS)) begin : g_bad_len
        $error("vga_encouracado: SHIP_LEN must be 1..BOARD_CELLS");
    end

    logic       on_board;
    logic [3:0] cell_row;
    logic [3:0] cell_col;
    logic       grid;

    vga_cell_locator #(
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0),
        .CELL_PX  (CELL_PX)
    ) u_locator (
        .linha    (linha),
        .coluna   (coluna),
        .on_board (on_board),
        .row      (cell_row),
        .col      (cell_col),
        .grid     (grid)
    );

    ship_desc_t desc;
    assign desc = ship_desc_t'(posicoesEmbarcacao);

    logic       desc_valid;
    logic       cross_ok;
    logic       along_ok;
    logic [3:0] seg;
    logic       on_ship;
    logic       seg_hit;

    // Ship membership. The along-axis test checks ordering before the
    // subtraction, so cells before the bow never wrap into a valid segment.
    // Segments beyond the last board cell are never reached because the
    // locator only yields rows/cols 0..9, which clips the ship naturally.
    always_comb begin
        desc_valid = (desc.row <= LAST_CELL) && (desc.col <= LAST_CELL);
        if (desc.vertical) begin
            cross_ok = (cell_col == desc.col);
            along_ok = (cell_row >= desc.row);
            seg      = cell_row - desc.row;
        end else begin
            cross_ok = (cell_row == desc.row);
            along_ok = (cell_col >= desc.col);
            seg      = cell_col - desc.col;
        end
        on_ship = desc_valid && cross_ok && along_ok && ({1'b0, seg} < SHIP_LEN_W);
        // Only the first HIT_BITS segments have a hit flag; later ones stay intact
        seg_hit = (seg < HIT_LIMIT) && desc.hits[seg[1:0]];
    end

    pix_class_t pix;

`ifdef VGA_ENCOURACADO_GRID_EN
    always_comb begin
        pix = PIX_WATER;
        if (!areaAtiva) begin
            pix = PIX_BLANK;
        end else if (!on_board) begin
            pix = PIX_BACKGROUND;
        end else if (grid) begin
            pix = PIX_GRID;
        end else if (on_ship && seg_hit) begin
            pix = PIX_HIT;
        end else if (on_ship) begin
            pix = PIX_SHIP;
        end
    end
`else
    logic unused_grid;
    assign unused_grid = grid;

    always_comb begin
        pix = PIX_WATER;
        if (!areaAtiva) begin
            pix = PIX_BLANK;
        end else if (!on_board) begin
            pix = PIX_BACKGROUND;
        end else if (on_ship && seg_hit) begin
            pix = PIX_HIT;
        end else if (on_ship) begin
            pix = PIX_SHIP;
        end
    end
`endif

    logic [8:0] rgb_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_reg <= BLACK;
        end else begin
            rgb_reg <= class_colour(pix);
        end
    end

    assign rgb_r = rgb_reg[8:6];
    assign rgb_g = rgb_reg[5:3];
    assign rgb_b = rgb_reg[2:0];

endmodule

// File: tb/tb_vga_encouracado.sv
// tb_vga_encouracado
//   Directed-vector bench for vga_encouracado. Colours are written in octal,
//   one digit per channel, e.g. 9'o026 = (r0, g2, b6). Expectations follow
//   VGA_ENCOURACADO_GRID_EN so the bench matches either build.
module tb_vga_encouracado;

    localparam logic [8:0] C_BLACK = 9'o000;
    localparam logic [8:0] C_BG    = 9'o111;
    localparam logic [8:0] C_GRID  = 9'o333;
    localparam logic [8:0] C_HIT   = 9'o700;
    localparam logic [8:0] C_SHIP  = 9'o555;
    localparam logic [8:0] C_WATER = 9'o026;

`ifdef VGA_ENCOURACADO_GRID_EN
    localparam logic [8:0] C_EDGE = C_GRID;
`else
    localparam logic [8:0] C_EDGE = C_WATER;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        area;
    logic [9:0]  linha;
    logic [9:0]  coluna;
    logic [12:0] desc;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [2:0]  b;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    vga_encouracado #(
        .BOARD_X0 (160),
        .BOARD_Y0 (80),
        .CELL_PX  (32),
        .SHIP_LEN (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .areaAtiva          (area),
        .linha              (linha),
        .coluna             (coluna),
        .posicoesEmbarcacao (desc),
        .rgb_r              (r),
        .rgb_g              (g),
        .rgb_b              (b)
    );

    function automatic logic [12:0] make_desc(input int unsigned row, input int unsigned col,
                                              input logic vertical, input logic [3:0] hits);
        return {hits, vertical, 4'(row), 4'(col)};
    endfunction

    task automatic check_rgb(input string tag, input logic [8:0] got, input logic [8:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: rgb got %o expected %o", tag, got, exp);
        end
    endtask

    // Drive one pixel on the falling edge, check the registered colour just after the next rising edge
    task automatic pixel(input string tag, input logic act, input int unsigned y, input int unsigned x,
                         input logic [12:0] d, input logic [8:0] exp);
        @(negedge clk);
        area   = act;
        linha  = 10'(y);
        coluna = 10'(x);
        desc   = d;
        @(posedge clk);
        #1;
        check_rgb(tag, {r, g, b}, exp);
    endtask

    logic [12:0] d_horiz;
    logic [12:0] d_vert;
    logic [12:0] d_vert_hit;
    logic [12:0] d_bow_hit;
    logic [12:0] d_bad_row;
    logic [12:0] d_bad_col;

    initial begin
        d_horiz    = make_desc(2, 3, 1'b0, 4'b0010);
        d_vert     = make_desc(8, 0, 1'b1, 4'b0000);
        d_vert_hit = make_desc(8, 0, 1'b1, 4'b0010);
        d_bow_hit  = make_desc(2, 3, 1'b0, 4'b0001);
        d_bad_row  = make_desc(12, 0, 1'b1, 4'b0000);
        d_bad_col  = make_desc(0, 10, 1'b0, 4'b0000);

        rst    = 1'b1;
        area   = 1'b0;
        linha  = '0;
        coluna = '0;
        desc   = '0;
        #1;
        check_rgb("reset_state", {r, g, b}, C_BLACK);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        pixel("outside_board",   1'b1, 10,  10,  d_horiz, C_BG);
        pixel("area_off",        1'b0, 154, 298, d_horiz, C_BLACK);
        pixel("board_corner",    1'b1, 80,  160, d_horiz, C_EDGE);
        pixel("water",           1'b1, 90,  170, d_horiz, C_WATER);
        pixel("h_bow_intact",    1'b1, 154, 266, d_horiz, C_SHIP);
        pixel("h_seg1_hit",      1'b1, 154, 298, d_horiz, C_HIT);
        pixel("h_seg3_intact",   1'b1, 154, 362, d_horiz, C_SHIP);
        pixel("h_past_stern",    1'b1, 154, 394, d_horiz, C_WATER);
        pixel("h_before_bow",    1'b1, 154, 234, d_horiz, C_WATER);
        pixel("h_other_row",     1'b1, 186, 266, d_horiz, C_WATER);
        pixel("h_bow_hit",       1'b1, 154, 266, d_bow_hit, C_HIT);
        pixel("v_row8",          1'b1, 346, 170, d_vert, C_SHIP);
        pixel("v_row9",          1'b1, 378, 170, d_vert, C_SHIP);
        pixel("v_clip_offboard", 1'b1, 405, 170, d_vert, C_BG);
        pixel("v_other_col",     1'b1, 346, 202, d_vert, C_WATER);
        pixel("v_seg1_hit",      1'b1, 378, 170, d_vert_hit, C_HIT);
        pixel("v_row0_top",      1'b1, 90,  170, d_vert, C_WATER);
        pixel("bad_row",         1'b1, 90,  170, d_bad_row, C_WATER);
        pixel("bad_row_r8",      1'b1, 346, 170, d_bad_row, C_WATER);
        pixel("bad_col",         1'b1, 90,  170, d_bad_col, C_WATER);
        pixel("left_of_board",   1'b1, 90,  159, d_horiz, C_BG);
        pixel("last_column",     1'b1, 90,  479, d_horiz, C_EDGE);
        pixel("right_of_board",  1'b1, 90,  480, d_horiz, C_BG);
        pixel("above_board",     1'b1, 79,  170, d_horiz, C_BG);
        pixel("last_line",       1'b1, 399, 170, d_horiz, C_EDGE);
        pixel("cell_edge_x",     1'b1, 90,  192, d_horiz, C_EDGE);
        pixel("pre_reset",       1'b1, 154, 266, d_horiz, C_SHIP);

        // Asynchronous reset mid-cycle: colour must clear without a clock edge
        #2;
        rst = 1'b1;
        #1;
        check_rgb("async_reset", {r, g, b}, C_BLACK);
        @(negedge clk);
        rst    = 1'b0;
        area   = 1'b1;
        linha  = 10'd10;
        coluna = 10'd10;
        @(posedge clk);
        #1;
        check_rgb("after_release", {r, g, b}, C_BG);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
